lsu_align: RTL and testbench

LSU_ALIGN -- requirements
Module: lsu_align

---
 rtl/lsu_pkg.sv | 42 ++++
 rtl/lsu_load_ext.sv | 47 ++++
 rtl/lsu_align.sv | 170 +++++++++++++++++
 tb/tb_lsu_align.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// ---------------------------------------------------------------------------
// lsu_pkg : funct3 encodings, FSM state and access-size types for lsu_align.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package lsu_pkg;

  localparam logic [2:0] c_f3_b  = 3'd0;
  localparam logic [2:0] c_f3_h  = 3'd1;
  localparam logic [2:0] c_f3_w  = 3'd2;
  localparam logic [2:0] c_f3_d  = 3'd3;
  localparam logic [2:0] c_f3_bu = 3'd4;
  localparam logic [2:0] c_f3_hu = 3'd5;
  localparam logic [2:0] c_f3_wu = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_t;

  function automatic logic misaligned(input size_t sz, input logic [2:0] off);
    case (sz)
      SZ_H:    return off[0];
      SZ_W:    return |off[1:0];
      SZ_D:    return |off[2:0];
      default: return 1'b0;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/lsu_load_ext.sv
// ---------------------------------------------------------------------------
// lsu_load_ext : combinational lane extraction and sign/zero extension of load data.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lsu_load_ext import lsu_pkg::*; #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]           i_rdata,
  input  logic [$clog2(XLEN/8)-1:0] i_offset,
  input  size_t                     i_size,
  input  logic                      i_unsigned,
  output logic [XLEN-1:0]           o_data
);

  logic [XLEN-1:0] w_shifted;
  logic [XLEN-1:0] w_b;
  logic [XLEN-1:0] w_h;
  logic [XLEN-1:0] w_w;

  assign w_shifted = i_rdata >> {i_offset, 3'b000};
  assign w_b = {{(XLEN-8){~i_unsigned & w_shifted[7]}}, w_shifted[7:0]};
  assign w_h = {{(XLEN-16){~i_unsigned & w_shifted[15]}}, w_shifted[15:0]};

  // A word only needs extending when it is narrower than the datapath.
  generate
    if (XLEN == 64) begin : g_w_ext
      assign w_w = {{(XLEN-32){~i_unsigned & w_shifted[31]}}, w_shifted[31:0]};
    end else begin : g_w_pass
      assign w_w = w_shifted;
    end
  endgenerate

  always_comb begin
    o_data = w_shifted;
    case (i_size)
      SZ_B:    o_data = w_b;
      SZ_H:    o_data = w_h;
      SZ_W:    o_data = w_w;
      default: o_data = w_shifted;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/lsu_align.sv
// ---------------------------------------------------------------------------
// lsu_align : load/store alignment unit between core and memory port.
// Macro LSU_RESP_REG_EN registers load response data (one extra cycle). Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module lsu_align import lsu_pkg::*; #(
  parameter int XLEN = 32,
  parameter int AW   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [AW-1:0]     req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_misaligned,
  output logic              resp_illegal,
  output logic              mem_req,
  input  logic              mem_gnt,
  output logic [AW-1:0]     mem_addr,
  output logic              mem_we,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_rvalid,
  input  logic [XLEN-1:0]   mem_rdata
);

  localparam int BEW  = XLEN / 8;
  localparam int OFFW = $clog2(BEW);

  state_t          r_state;
  state_t          w_next;
  logic            r_we;
  logic            r_uns;
  logic            r_ill;
  logic            r_mis;
  size_t           r_size;
  logic [AW-1:0]   r_addr;
  logic [XLEN-1:0] r_wdata;

  logic            w_accept;
  logic            w_ill;
  logic            w_mis;
  logic            w_uns;
  size_t           w_size;
  logic [BEW-1:0]  w_mask;
  logic [XLEN-1:0] w_ext;

  assign req_ready = (r_state == S_IDLE) && rst_n;
  assign w_accept  = req_valid && req_ready;

  always_comb begin
    w_size = SZ_B;
    w_uns  = 1'b0;
    w_ill  = 1'b0;
    case (req_funct3)
      c_f3_b:  w_size = SZ_B;
      c_f3_h:  w_size = SZ_H;
      c_f3_w:  w_size = SZ_W;
      c_f3_bu: begin w_size = SZ_B; w_uns = 1'b1; w_ill = req_we; end
      c_f3_hu: begin w_size = SZ_H; w_uns = 1'b1; w_ill = req_we; end
      c_f3_d:  begin w_size = SZ_D; w_ill = (XLEN != 64); end
      c_f3_wu: begin w_size = SZ_W; w_uns = 1'b1; w_ill = (XLEN != 64) || req_we; end
      default: w_ill = 1'b1;
    endcase
    w_mis = misaligned(w_size, req_addr[2:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_next = (w_ill || w_mis) ? S_RESP : S_REQ;
      // A simultaneous rvalid is ignored here; data must follow the grant.
      S_REQ:  if (mem_gnt) w_next = r_we ? S_RESP : S_WAIT;
`ifdef LSU_RESP_REG_EN
      S_WAIT: if (mem_rvalid) w_next = S_RESP;
`else
      S_WAIT: if (mem_rvalid) w_next = S_IDLE;
`endif
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_we    <= 1'b0;
      r_uns   <= 1'b0;
      r_ill   <= 1'b0;
      r_mis   <= 1'b0;
      r_size  <= SZ_B;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_we    <= req_we;
      r_uns   <= w_uns;
      r_ill   <= w_ill;
      r_mis   <= w_mis & ~w_ill;
      r_size  <= w_size;
      r_addr  <= req_addr;
      r_wdata <= req_wdata;
    end
  end

  always_comb begin
    w_mask    = '1;
    mem_wdata = r_wdata;
    case (r_size)
      SZ_B: begin w_mask = BEW'(1);  mem_wdata = {BEW{r_wdata[7:0]}}; end
      SZ_H: begin w_mask = BEW'(3);  mem_wdata = {(BEW/2){r_wdata[15:0]}}; end
      SZ_W: begin w_mask = BEW'(15); mem_wdata = {(XLEN/32){r_wdata[31:0]}}; end
      default: begin w_mask = '1; mem_wdata = r_wdata; end
    endcase
  end

  assign mem_req  = (r_state == S_REQ);
  assign mem_we   = mem_req & r_we;
  assign mem_addr = {r_addr[AW-1:OFFW], {OFFW{1'b0}}};
  assign mem_be   = mem_req ? (w_mask << r_addr[OFFW-1:0]) : '0;

  lsu_load_ext #(.XLEN(XLEN)) u_load_ext (
    .i_rdata    (mem_rdata),
    .i_offset   (r_addr[OFFW-1:0]),
    .i_size     (r_size),
    .i_unsigned (r_uns),
    .o_data     (w_ext)
  );

`ifdef LSU_RESP_REG_EN
  logic [XLEN-1:0] r_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (w_accept) begin
      r_rdata <= '0;
    end else if (r_state == S_WAIT && mem_rvalid) begin
      r_rdata <= w_ext;
    end
  end

  assign resp_valid = (r_state == S_RESP);
  assign resp_rdata = resp_valid ? r_rdata : '0;
`else
  logic w_load_done;

  assign w_load_done = (r_state == S_WAIT) && mem_rvalid;
  assign resp_valid  = (r_state == S_RESP) || w_load_done;
  assign resp_rdata  = w_load_done ? w_ext : '0;
`endif

  assign resp_misaligned = (r_state == S_RESP) & r_mis;
  assign resp_illegal    = (r_state == S_RESP) & r_ill;

endmodule

`default_nettype wire

// File: tb/tb_lsu_align.sv
// ---------------------------------------------------------------------------
// tb_lsu_align : directed self-checking bench for lsu_align (XLEN=32 and XLEN=64).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_lsu_align;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_misaligned, resp_illegal;
  logic [31:0] resp_rdata;
  logic        mem_req, mem_gnt, mem_we, mem_rvalid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_be;

  logic        d_req_valid, d_req_ready, d_req_we;
  logic [2:0]  d_req_funct3;
  logic [31:0] d_req_addr;
  logic [63:0] d_req_wdata;
  logic        d_resp_valid, d_resp_misaligned, d_resp_illegal;
  logic [63:0] d_resp_rdata;
  logic        d_mem_req, d_mem_gnt, d_mem_we, d_mem_rvalid;
  logic [31:0] d_mem_addr;
  logic [63:0] d_mem_wdata, d_mem_rdata;
  logic [7:0]  d_mem_be;

  int n_vec = 0;
  int n_err = 0;

  lsu_align #(.XLEN(32), .AW(32)) u_dut32 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misaligned(resp_misaligned), .resp_illegal(resp_illegal),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  lsu_align #(.XLEN(64), .AW(32)) u_dut64 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(d_req_valid), .req_ready(d_req_ready), .req_we(d_req_we),
    .req_funct3(d_req_funct3), .req_addr(d_req_addr), .req_wdata(d_req_wdata),
    .resp_valid(d_resp_valid), .resp_rdata(d_resp_rdata),
    .resp_misaligned(d_resp_misaligned), .resp_illegal(d_resp_illegal),
    .mem_req(d_mem_req), .mem_gnt(d_mem_gnt), .mem_addr(d_mem_addr), .mem_we(d_mem_we),
    .mem_be(d_mem_be), .mem_wdata(d_mem_wdata), .mem_rvalid(d_mem_rvalid), .mem_rdata(d_mem_rdata)
  );

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [3:0]  be;
    logic [31:0] exp;
    int          gd;
    logic        rv_gnt;
  } ld_vec_t;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_addr;
    logic [3:0]  be;
    logic [31:0] exp_wdata;
    int          gd;
  } st_vec_t;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic        ill;
    logic        mis;
  } err_vec_t;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [63:0] rdata;
    logic [31:0] exp_addr;
    logic [7:0]  be;
    logic [63:0] exp;
  } ld64_vec_t;

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0; req_addr = '0; req_wdata = '0;
  endtask

  task automatic d_issue(input logic [2:0] f3, input logic [31:0] a);
    @(negedge clk);
    d_req_valid = 1'b1; d_req_we = 1'b0; d_req_funct3 = f3; d_req_addr = a;
    @(posedge clk); #1;
    d_req_valid = 1'b0; d_req_funct3 = 3'd0; d_req_addr = '0;
  endtask

  task automatic test_reset();
    req_valid = 0; req_we = 0; req_funct3 = 0; req_addr = 0; req_wdata = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;
    d_req_valid = 0; d_req_we = 0; d_req_funct3 = 0; d_req_addr = 0; d_req_wdata = 0;
    d_mem_gnt = 0; d_mem_rvalid = 0; d_mem_rdata = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_vec++;
    if ({req_ready, mem_req, resp_valid, resp_misaligned, resp_illegal} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctl32: got %b exp 00000",
               {req_ready, mem_req, resp_valid, resp_misaligned, resp_illegal});
    end
    n_vec++;
    if ({resp_rdata, mem_be} !== 36'h0) begin
      n_err++;
      $display("FAIL reset_data32: got rdata %h be %b exp 0", resp_rdata, mem_be);
    end
    n_vec++;
    if ({d_req_ready, d_mem_req, d_resp_valid, d_resp_rdata, d_mem_be} !== 75'h0) begin
      n_err++;
      $display("FAIL reset64: got ready %b req %b rv %b rdata %h be %h exp 0",
               d_req_ready, d_mem_req, d_resp_valid, d_resp_rdata, d_mem_be);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++;
    if ({req_ready, d_req_ready} !== 2'b11) begin
      n_err++;
      $display("FAIL reset_release: got %b exp 11", {req_ready, d_req_ready});
    end
  endtask

  task automatic test_loads();
    ld_vec_t v[6];
    v[0] = '{3'd0, 32'h103, 32'h80FF_1234, 32'h100, 4'b1000, 32'hFFFF_FF80, 0, 1'b0};
    v[1] = '{3'd4, 32'h101, 32'h80FF_1234, 32'h100, 4'b0010, 32'h0000_0012, 2, 1'b1};
    v[2] = '{3'd1, 32'h102, 32'h80FF_1234, 32'h100, 4'b1100, 32'hFFFF_80FF, 1, 1'b0};
    v[3] = '{3'd5, 32'h102, 32'h80FF_1234, 32'h100, 4'b1100, 32'h0000_80FF, 0, 1'b1};
    v[4] = '{3'd2, 32'h104, 32'hDEAD_BEEF, 32'h104, 4'b1111, 32'hDEAD_BEEF, 0, 1'b0};
    v[5] = '{3'd0, 32'h200, 32'h0000_007F, 32'h200, 4'b0001, 32'h0000_007F, 1, 1'b0};
    for (int i = 0; i < 6; i++) begin
      issue(1'b0, v[i].f3, v[i].addr, 32'h5555_5555);
      for (int k = 0; k <= v[i].gd; k++) begin
        @(negedge clk);
        mem_gnt = (k == v[i].gd);
        mem_rvalid = (k == v[i].gd) && v[i].rv_gnt;
        mem_rdata = v[i].rdata;
        #1;
        n_vec++;
        if ({mem_req, mem_we, mem_addr, mem_be, resp_valid} !==
            {1'b1, 1'b0, v[i].exp_addr, v[i].be, 1'b0}) begin
          n_err++;
          $display("FAIL ld_req[%0d]: got req %b we %b addr %h be %b rv %b exp 1 0 %h %b 0",
                   i, mem_req, mem_we, mem_addr, mem_be, resp_valid, v[i].exp_addr, v[i].be);
        end
      end
      @(negedge clk);
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      #1;
      n_vec++;
      if ({mem_req, resp_valid} !== 2'b00) begin
        n_err++;
        $display("FAIL ld_wait[%0d]: got req %b rv %b exp 0 0", i, mem_req, resp_valid);
      end
      @(negedge clk);
      mem_rvalid = 1'b1;
      #1;
`ifdef LSU_RESP_REG_EN
      n_vec++;
      if (resp_valid !== 1'b0) begin
        n_err++;
        $display("FAIL ld_early[%0d]: got rv %b exp 0", i, resp_valid);
      end
      @(negedge clk);
      mem_rvalid = 1'b0; mem_rdata = ~v[i].rdata;
      #1;
`endif
      n_vec++;
      if ({resp_valid, resp_rdata, resp_misaligned, resp_illegal} !== {1'b1, v[i].exp, 2'b00}) begin
        n_err++;
        $display("FAIL ld_resp[%0d]: got rv %b rdata %h mis %b ill %b exp 1 %h 0 0",
                 i, resp_valid, resp_rdata, resp_misaligned, resp_illegal, v[i].exp);
      end
      @(negedge clk);
      mem_rvalid = 1'b0;
      #1;
      n_vec++;
      if ({resp_valid, req_ready} !== 2'b01) begin
        n_err++;
        $display("FAIL ld_done[%0d]: got rv %b ready %b exp 0 1", i, resp_valid, req_ready);
      end
    end
  endtask

  task automatic test_stores();
    st_vec_t v[4];
    v[0] = '{3'd1, 32'h102, 32'h0000_ABCD, 32'h100, 4'b1100, 32'hABCD_ABCD, 3};
    v[1] = '{3'd0, 32'h101, 32'h1234_5678, 32'h100, 4'b0010, 32'h7878_7878, 0};
    v[2] = '{3'd2, 32'h100, 32'hCAFE_F00D, 32'h100, 4'b1111, 32'hCAFE_F00D, 1};
    v[3] = '{3'd1, 32'h200, 32'h0000_1357, 32'h200, 4'b0011, 32'h1357_1357, 0};
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, v[i].f3, v[i].addr, v[i].wdata);
      for (int k = 0; k <= v[i].gd; k++) begin
        @(negedge clk);
        mem_gnt = (k == v[i].gd);
        #1;
        n_vec++;
        if ({mem_req, mem_we, mem_addr, mem_be, mem_wdata, resp_valid} !==
            {1'b1, 1'b1, v[i].exp_addr, v[i].be, v[i].exp_wdata, 1'b0}) begin
          n_err++;
          $display("FAIL st_req[%0d.%0d]: got req %b we %b addr %h be %b wd %h rv %b exp 1 1 %h %b %h 0",
                   i, k, mem_req, mem_we, mem_addr, mem_be, mem_wdata, resp_valid,
                   v[i].exp_addr, v[i].be, v[i].exp_wdata);
        end
      end
      @(negedge clk);
      mem_gnt = 1'b0;
      #1;
      n_vec++;
      if ({resp_valid, resp_rdata, resp_misaligned, resp_illegal, mem_req} !==
          {1'b1, 32'h0, 3'b000}) begin
        n_err++;
        $display("FAIL st_resp[%0d]: got rv %b rdata %h mis %b ill %b req %b exp 1 0 0 0 0",
                 i, resp_valid, resp_rdata, resp_misaligned, resp_illegal, mem_req);
      end
      @(negedge clk);
      #1;
      n_vec++;
      if ({resp_valid, req_ready} !== 2'b01) begin
        n_err++;
        $display("FAIL st_done[%0d]: got rv %b ready %b exp 0 1", i, resp_valid, req_ready);
      end
    end
  endtask

  task automatic test_errors();
    err_vec_t v[8];
    v[0] = '{1'b0, 3'd2, 32'h101, 1'b0, 1'b1};
    v[1] = '{1'b0, 3'd1, 32'h103, 1'b0, 1'b1};
    v[2] = '{1'b0, 3'd3, 32'h100, 1'b1, 1'b0};
    v[3] = '{1'b0, 3'd7, 32'h100, 1'b1, 1'b0};
    v[4] = '{1'b1, 3'd4, 32'h100, 1'b1, 1'b0};
    v[5] = '{1'b0, 3'd3, 32'h101, 1'b1, 1'b0};
    v[6] = '{1'b0, 3'd6, 32'h100, 1'b1, 1'b0};
    v[7] = '{1'b1, 3'd2, 32'h102, 1'b0, 1'b1};
    for (int i = 0; i < 8; i++) begin
      issue(v[i].we, v[i].f3, v[i].addr, 32'hFFFF_FFFF);
      @(negedge clk);
      #1;
      n_vec++;
      if ({resp_valid, resp_illegal, resp_misaligned, resp_rdata, mem_req} !==
          {1'b1, v[i].ill, v[i].mis, 32'h0, 1'b0}) begin
        n_err++;
        $display("FAIL err_resp[%0d]: got rv %b ill %b mis %b rdata %h req %b exp 1 %b %b 0 0",
                 i, resp_valid, resp_illegal, resp_misaligned, resp_rdata, mem_req,
                 v[i].ill, v[i].mis);
      end
      @(negedge clk);
      #1;
      n_vec++;
      if ({resp_valid, req_ready, mem_req} !== 3'b010) begin
        n_err++;
        $display("FAIL err_done[%0d]: got rv %b ready %b req %b exp 0 1 0",
                 i, resp_valid, req_ready, mem_req);
      end
    end
  endtask

  task automatic test_ignore_idle();
    @(negedge clk);
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    #1;
    n_vec++;
    if ({mem_req, resp_valid, req_ready} !== 3'b001) begin
      n_err++;
      $display("FAIL ign_idle0: got req %b rv %b ready %b exp 0 0 1", mem_req, resp_valid, req_ready);
    end
    @(negedge clk);
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    #1;
    n_vec++;
    if ({mem_req, resp_valid, req_ready} !== 3'b001) begin
      n_err++;
      $display("FAIL ign_idle1: got req %b rv %b ready %b exp 0 0 1", mem_req, resp_valid, req_ready);
    end
  endtask

  task automatic test_reset_mid();
    issue(1'b0, 3'd2, 32'h100, 32'h0);
    @(negedge clk);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({req_ready, mem_req, resp_valid, mem_be, resp_rdata} !== 39'h0) begin
      n_err++;
      $display("FAIL rst_mid: got ready %b req %b rv %b be %b rdata %h exp 0",
               req_ready, mem_req, resp_valid, mem_be, resp_rdata);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (req_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_rel: got ready %b exp 1", req_ready);
    end
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    #1;
    n_vec++;
    if ({resp_valid, req_ready, mem_req} !== 3'b010) begin
      n_err++;
      $display("FAIL rst_late_rv: got rv %b ready %b req %b exp 0 1 0", resp_valid, req_ready, mem_req);
    end
    @(negedge clk);
    mem_rvalid = 1'b0; mem_gnt = 1'b1;
    #1;
    @(negedge clk);
    mem_gnt = 1'b0;
    #1;
    n_vec++;
    if ({resp_valid, req_ready, mem_req} !== 3'b010) begin
      n_err++;
      $display("FAIL rst_late_gnt: got rv %b ready %b req %b exp 0 1 0", resp_valid, req_ready, mem_req);
    end
  endtask

  task automatic test_xlen64();
    ld64_vec_t v[4];
    v[0] = '{3'd6, 32'h4,  64'h8000_0001_0000_0000, 32'h0,  8'hF0, 64'h0000_0000_8000_0001};
    v[1] = '{3'd2, 32'h4,  64'h8000_0001_0000_0000, 32'h0,  8'hF0, 64'hFFFF_FFFF_8000_0001};
    v[2] = '{3'd3, 32'h10, 64'h0123_4567_89AB_CDEF, 32'h10, 8'hFF, 64'h0123_4567_89AB_CDEF};
    v[3] = '{3'd1, 32'h16, 64'h0123_4567_89AB_CDEF, 32'h10, 8'hC0, 64'h0000_0000_0000_0123};
    for (int i = 0; i < 4; i++) begin
      d_issue(v[i].f3, v[i].addr);
      @(negedge clk);
      d_mem_gnt = 1'b1; d_mem_rdata = v[i].rdata;
      #1;
      n_vec++;
      if ({d_mem_req, d_mem_we, d_mem_addr, d_mem_be} !== {1'b1, 1'b0, v[i].exp_addr, v[i].be}) begin
        n_err++;
        $display("FAIL ld64_req[%0d]: got req %b we %b addr %h be %h exp 1 0 %h %h",
                 i, d_mem_req, d_mem_we, d_mem_addr, d_mem_be, v[i].exp_addr, v[i].be);
      end
      @(negedge clk);
      d_mem_gnt = 1'b0; d_mem_rvalid = 1'b1;
      #1;
`ifdef LSU_RESP_REG_EN
      n_vec++;
      if (d_resp_valid !== 1'b0) begin
        n_err++;
        $display("FAIL ld64_early[%0d]: got rv %b exp 0", i, d_resp_valid);
      end
      @(negedge clk);
      d_mem_rvalid = 1'b0; d_mem_rdata = ~v[i].rdata;
      #1;
`endif
      n_vec++;
      if ({d_resp_valid, d_resp_rdata} !== {1'b1, v[i].exp}) begin
        n_err++;
        $display("FAIL ld64_resp[%0d]: got rv %b rdata %h exp 1 %h", i, d_resp_valid, d_resp_rdata, v[i].exp);
      end
      @(negedge clk);
      d_mem_rvalid = 1'b0;
      #1;
      n_vec++;
      if ({d_resp_valid, d_req_ready} !== 2'b01) begin
        n_err++;
        $display("FAIL ld64_done[%0d]: got rv %b ready %b exp 0 1", i, d_resp_valid, d_req_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ignore_idle();
    test_loads();
    test_stores();
    test_errors();
    test_reset_mid();
    test_xlen64();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete within 200000 ns");
    $fatal(1);
  end

endmodule

`default_nettype wire
